// File: rtl/clock_delay_ctrl_m.sv
// Sequencer for a chain of clock-delay slices: moves the applied tap count toward a
// requested target one slice at a time, waiting for a quiet window and a settle interval per step.
module clock_delay_ctrl_m #(
    parameter int NSLICE = 4,
    parameter int SETTLE = 8,
    parameter int TW     = 3
) (
    input  logic              ck_ip,
    input  logic              rst_ip,
    input  logic              req_ip,
    input  logic [TW-1:0]     taps_ip,
    input  logic              hold_ip,
    output logic              ack_op,
    output logic              busy_op,
    output logic [TW-1:0]     taps_op,
    output logic [NSLICE-1:0] bypass_op
);

    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_SETTLE
    } state_t;

    state_t              state, state_n;
    logic [TW-1:0]       target, target_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [TW-1:0]       taps_n;
    logic [NSLICE-1:0]   bypass_n;
    logic                ack_n;
    logic                busy_n;
    logic [TW-1:0]       req_clamped;

    function automatic logic [TW-1:0] clamp_taps(input logic [TW-1:0] t);
        if (t > TW'(NSLICE))
            return TW'(NSLICE);
        return t;
    endfunction

    // Slices below the tap count are delayed; the rest are bypassed.
    function automatic logic [NSLICE-1:0] thermo_bypass(input logic [TW-1:0] t);
        logic [NSLICE-1:0] b;
        for (int i = 0; i < NSLICE; i++)
            b[i] = (TW'(i) >= t);
        return b;
    endfunction

    assign req_clamped = clamp_taps(taps_ip);

    always_ff @(posedge ck_ip) begin
        if (rst_ip) begin
            state     <= ST_IDLE;
            target    <= '0;
            cnt       <= '0;
            taps_op   <= '0;
            bypass_op <= '1;
            ack_op    <= 1'b0;
            busy_op   <= 1'b0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            cnt       <= cnt_n;
            taps_op   <= taps_n;
            bypass_op <= bypass_n;
            ack_op    <= ack_n;
            busy_op   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        target_n = target;
        cnt_n    = cnt;
        taps_n   = taps_op;
        bypass_n = bypass_op;
        ack_n    = 1'b0;
        busy_n   = busy_op;
        case (state)
            ST_IDLE: begin
                if (req_ip) begin
                    target_n = req_clamped;
                    if (req_clamped == taps_op) begin
                        ack_n = 1'b1;
                    end else begin
                        busy_n  = 1'b1;
                        state_n = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                if (!hold_ip) begin
                    if (target > taps_op)
                        taps_n = taps_op + TW'(1);
                    else
                        taps_n = taps_op - TW'(1);
                    bypass_n = thermo_bypass(taps_n);
                    cnt_n    = CW'(SETTLE - 1);
                    state_n  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    if (taps_op == target) begin
                        ack_n   = 1'b1;
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_STEP;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clock_delay_ctrl_m.sv
// Directed bench for clock_delay_ctrl_m with NSLICE=4, SETTLE=3.
module tb_clock_delay_ctrl_m;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [2:0] taps_in;
    logic       hold;
    logic       ack;
    logic       busy;
    logic [2:0] taps_out;
    logic [3:0] bypass;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;

    clock_delay_ctrl_m #(.NSLICE(4), .SETTLE(3), .TW(3)) dut (
        .ck_ip     (clk),
        .rst_ip    (rst),
        .req_ip    (req),
        .taps_ip   (taps_in),
        .hold_ip   (hold),
        .ack_op    (ack),
        .busy_op   (busy),
        .taps_op   (taps_out),
        .bypass_op (bypass)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ack === 1'b1)
            ack_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues a request and checks every cycle until the ack, assuming hold stays low.
    task automatic run_req(input logic [2:0] reqv, input int start, input int tgt);
        int d;
        int dir;
        int total;
        int exp_t;
        logic [3:0] ones;
        ones  = 4'hF;
        d     = (tgt > start) ? tgt - start : start - tgt;
        dir   = (tgt > start) ? 1 : -1;
        total = d * 4;
        req     = 1'b1;
        taps_in = reqv;
        tick();
        req     = 1'b0;
        taps_in = 3'd0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ack", 32'(ack), 32'd0);
        for (int c = 1; c <= total; c++) begin
            tick();
            exp_t = start + dir * ((c + 3) / 4);
            chk("seq_taps", 32'(taps_out), 32'(exp_t));
            chk("seq_bypass", 32'(bypass), 32'(4'(ones << exp_t)));
            chk("seq_ack", 32'(ack), (c == total) ? 32'd1 : 32'd0);
            chk("seq_busy", 32'(busy), (c == total) ? 32'd0 : 32'd1);
        end
        tick();
        chk("ack_clear", 32'(ack), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        req     = 1'b0;
        taps_in = 3'd0;
        hold    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_taps", 32'(taps_out), 32'd0);
        chk("rst_bypass", 32'(bypass), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);

        // 0 -> 2: explicit edge-by-edge expectations
        req = 1'b1; taps_in = 3'd2;
        tick();
        req = 1'b0;
        chk("t1_k_busy", 32'(busy), 32'd1);
        chk("t1_k_bypass", 32'(bypass), 32'hF);
        tick();
        chk("t1_k1_bypass", 32'(bypass), 32'hE);
        chk("t1_k1_taps", 32'(taps_out), 32'd1);
        tick(); tick(); tick();
        chk("t1_k4_bypass", 32'(bypass), 32'hE);
        tick();
        chk("t1_k5_bypass", 32'(bypass), 32'hC);
        tick(); tick();
        chk("t1_k7_ack", 32'(ack), 32'd0);
        chk("t1_k7_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_k8_ack", 32'(ack), 32'd1);
        chk("t1_k8_busy", 32'(busy), 32'd0);
        chk("t1_k8_taps", 32'(taps_out), 32'd2);
        tick();
        chk("t1_ack_clear", 32'(ack), 32'd0);

        // Request equal to current tap count
        req = 1'b1; taps_in = 3'd2;
        tick();
        req = 1'b0;
        chk("eq_ack", 32'(ack), 32'd1);
        chk("eq_busy", 32'(busy), 32'd0);
        chk("eq_bypass", 32'(bypass), 32'hC);
        tick();
        chk("eq_ack_clear", 32'(ack), 32'd0);
        chk("eq_busy2", 32'(busy), 32'd0);

        // 2 -> 0
        run_req(3'd0, 2, 0);
        chk("t2_bypass_end", 32'(bypass), 32'hF);

        // Reset while settling after the first step toward 3
        req = 1'b1; taps_in = 3'd3;
        tick();
        req = 1'b0;
        tick();
        chk("rs_taps1", 32'(taps_out), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_bypass", 32'(bypass), 32'hF);
        chk("rs_taps", 32'(taps_out), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("rs_no_ack", 32'(ack), 32'd0);
        chk("rs_idle_taps", 32'(taps_out), 32'd0);

        // Clamp 7 -> 4
        run_req(3'd7, 0, 4);
        chk("clamp_bypass", 32'(bypass), 32'h0);
        chk("clamp_taps", 32'(taps_out), 32'd4);

        // 4 -> 1 with a hold window, a stray request, and a taps change while busy
        req = 1'b1; taps_in = 3'd1;
        tick();
        req  = 1'b0;
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                req = 1'b1; taps_in = 3'd0;
            end else begin
                req = 1'b0;
            end
            tick();
            chk("hold_bypass", 32'(bypass), 32'h0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        req  = 1'b0;
        hold = 1'b0;
        tick();
        chk("rel_bypass", 32'(bypass), 32'h8);
        chk("rel_taps", 32'(taps_out), 32'd3);
        tick(); tick(); tick();
        chk("h_settle_bypass", 32'(bypass), 32'h8);
        tick();
        chk("h_step2_bypass", 32'(bypass), 32'hC);
        tick(); tick(); tick();
        tick();
        chk("h_step3_bypass", 32'(bypass), 32'hE);
        chk("h_step3_taps", 32'(taps_out), 32'd1);
        tick(); tick();
        chk("h_pre_ack", 32'(ack), 32'd0);
        tick();
        chk("h_ack", 32'(ack), 32'd1);
        chk("h_taps_final", 32'(taps_out), 32'd1);
        tick();
        chk("h_ack_clear", 32'(ack), 32'd0);
        chk("h_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("ack_total", 32'(ack_cnt), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_delay_ctrl_m.md
Name: clock_delay_ctrl_m

Overview:
- Sequencer for a chain of NSLICE clock-delay slices. Each slice passes its input clock either straight through or via a buffer delay, selected by its bypass input.
- Accepts a requested tap count (number of slices in delay mode) over a req/ack handshake.
- Walks the bypass vector toward the target one slice at a time. Each change waits for a quiet window (hold_ip low) and is followed by a settle interval, so the output clock never sees a multi-slice jump or a glitch.
- Sits in the clock-control block beside the delay chain. It is driven from the configuration/CPU-interface logic.

Parameters:
- NSLICE, 4, number of delay slices controlled (1..15).
- SETTLE, 8, clock cycles waited after each single-slice change (>=1).
- TW, 3, width of tap-count fields; must satisfy 2^TW > NSLICE.

Ports:
- ck_ip  input  1  system clock; all state updates on rising edge.
- rst_ip  input  1  reset, synchronous, active-high.
- req_ip  input  1  request; sampled only in IDLE.
- taps_ip  input  TW  requested tap count; values above NSLICE are clamped to NSLICE.
- hold_ip  input  1  high = unsafe window; no slice change may be issued.
- ack_op  output  1  one-cycle pulse: request complete.
- busy_op  output  1  high while a request is in progress.
- taps_op  output  TW  current applied tap count.
- bypass_op  output  NSLICE  bypass_op[i] = 1 when i >= taps_op (slice 0 is delayed first).

Behaviour:
- All outputs are registered.
- On a rising edge with rst_ip=1, regardless of state: taps_op=0, bypass_op=all ones, ack_op=0, busy_op=0, settle counter=0, target=0, state=IDLE. Reset mid-sequence abandons the request with no ack.
- States: IDLE, STEP, SETTLE.
- IDLE:
  - req_ip=1: latch target=min(taps_ip,NSLICE).
  - If target==taps_op: ack_op=1 next cycle, busy_op stays 0, remain IDLE.
  - Otherwise: busy_op=1, go to STEP.
- STEP:
  - hold_ip=1: remain in STEP; outputs unchanged. There is no timeout.
  - hold_ip=0: taps_op moves by +1 if target>taps_op, else by -1. bypass_op is updated in the same edge (exactly one bit toggles). Counter=SETTLE-1, go to SETTLE.
- SETTLE:
  - Counter decrements once per edge.
  - At an edge with counter==0 and taps_op==target: ack_op=1, busy_op=0, go to IDLE.
  - At an edge with counter==0 and taps_op!=target: go to STEP.
  - hold_ip is ignored during SETTLE.
- ack_op is high for exactly one cycle and cleared on the following edge.
- Latency: request accepted at edge k with d=|target-taps_op| and hold_ip low throughout → ack_op high in the cycle after edge k+d*(SETTLE+1).
- req_ip while busy_op=1 is ignored; it is not queued. A req_ip still high in IDLE after an ack starts a new request (level-sensitive).
- Boundaries:
  - taps_op never leaves 0..NSLICE.
  - Exactly one bypass_op bit changes per STEP.
  - No bypass_op change occurs during SETTLE or IDLE.
  - The target is frozen once accepted; a change on taps_ip mid-sequence has no effect.

Test Plan (NSLICE=4, SETTLE=3):
- Reset → taps_op=0, bypass_op=4'b1111, busy_op=0, ack_op=0. Apply req_ip with taps_ip=2 at edge k, hold_ip=0 → bypass_op=1110 after edge k+1, then 1100 after edge k+5; ack_op high after edge k+8 for one cycle; busy_op low with ack.
- From taps_op=2, request taps_ip=0 → bypass_op steps 1100→1110→1111, one bit per step, 4 cycles apart; ack after 8 cycles.
- Request taps_ip=7 from taps_op=0 → clamped to 4; bypass_op ends at 0000 after 4 steps; taps_op=4; ack once.
- Request equal to current (taps_ip=2, taps_op=2) → ack_op pulses the next cycle; busy_op stays 0; bypass_op unchanged.
- Hold and ignore:
  - hold_ip=1 for 10 cycles while in STEP → no bypass_op change during hold; step issued on the first edge with hold_ip=0.
  - A second req_ip pulse while busy_op=1 is ignored (ack count=1).
- Assert rst_ip in SETTLE mid-sequence (taps_op=1, target=3) → next edge: bypass_op=1111, taps_op=0, busy_op=0, no ack_op. A subsequent request operates normally.
